adder_serial_bk: RTL and testbench

Nibble-serial add/subtract unit. It accepts two WIDTH-bit operands through a valid/ready handshake and processes one 4-bit slice per clock. Each slice is built as a prop/gen stage feeding a 4-bit Brent-Kung carry tree, followed by a sum stage, with the carry chained between cycles through a register. It is the area-optimised datapath adder for slow-path arithmetic where latency is cheap and gates are not.

---
 rtl/adder_pkg.sv | 28 ++
 rtl/carry_tree_bk_4b.sv | 36 +++
 rtl/adder_serial_bk.sv | 158 +++++++++++++++
 tb/tb_adder_serial_bk.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/adder_pkg.sv
// ============================================================================
//  Module   : adder_pkg
//  Purpose  : Shared types and helpers for the nibble-serial adder.
//             - state_e   : controller states (IDLE, RUN, DONE)
//             - NIBBLE_W  : bits handled per clock
//             - cnt_width : width of the nibble counter for a given WIDTH
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package adder_pkg;

    localparam int NIBBLE_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    // Counter must index nibbles 0..WIDTH/4-1.
    function automatic int cnt_width(input int width);
        return $clog2(width / NIBBLE_W);
    endfunction

endpackage

`default_nettype wire

// File: rtl/carry_tree_bk_4b.sv
// ============================================================================
//  Module   : carry_tree_bk_4b
//  Purpose  : 4-bit Brent-Kung carry tree. Produces the group generate of
//             bits j..0 for every j in the nibble.
//  Ports    : i_p  [3:1] bit propagates (bit 0 is already folded into i_g[0])
//             i_g  [3:0] bit generates, i_g[0] carries the incoming carry
//             o_cx [3:0] group generates G[j:0]
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module carry_tree_bk_4b (
    input  logic [3:1] i_p,
    input  logic [3:0] i_g,
    output logic [3:0] o_cx
);

    // Up-sweep: pairwise combine, then combine the two pairs.
    logic w_g10;
    logic w_g32;
    logic w_p32;
    logic w_g30;
    // Down-sweep: fill in the odd prefix left by the up-sweep.
    logic w_g20;

    assign w_g10 = i_g[1] | (i_p[1] & i_g[0]);
    assign w_g32 = i_g[3] | (i_p[3] & i_g[2]);
    assign w_p32 = i_p[3] & i_p[2];
    assign w_g30 = w_g32 | (w_p32 & w_g10);
    assign w_g20 = i_g[2] | (i_p[2] & w_g10);

    assign o_cx = {w_g30, w_g20, w_g10, i_g[0]};

endmodule

`default_nettype wire

// File: rtl/adder_serial_bk.sv
// ============================================================================
//  Module   : adder_serial_bk
//  Purpose  : Nibble-serial add/subtract unit. Operands are captured on a
//             valid/ready handshake, then one 4-bit slice is summed per clock
//             through a Brent-Kung carry tree with a registered inter-nibble
//             carry. The result is held until the consumer accepts it.
//  Ports    : clk_i, rst_i (sync, active-high)
//             in_valid_i / in_ready_o   : operand handshake
//             a_i, b_i, carry_i, sub_i  : operands and operation select
//             out_valid_o / out_ready_i : result handshake
//             sum_o, carry_o, overflow_o: registered result and flags
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module adder_serial_bk
    import adder_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic             carry_i,
    input  logic             sub_i,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [WIDTH-1:0] sum_o,
    output logic             carry_o,
    output logic             overflow_o
);

    localparam int                 c_N        = WIDTH / NIBBLE_W;
    localparam int                 c_CNT_W    = cnt_width(WIDTH);
    localparam logic [c_CNT_W-1:0] c_LAST_NIB = c_CNT_W'(c_N - 1);

    state_e             r_state;
    state_e             w_state_nxt;
    logic [c_CNT_W-1:0] r_cnt;
    logic [WIDTH-1:0]   r_a;
    logic [WIDTH-1:0]   r_b;
    logic               r_carry;
    logic [WIDTH-1:0]   r_result;
    logic               r_carry_out;
    logic               r_ovf;

    logic               w_last;
    logic [3:0]         w_p;
    logic [3:0]         w_g;
    logic [3:0]         w_g_fold;
    logic [3:0]         w_cx;
    logic [3:0]         w_sum;

    assign w_last = (r_cnt == c_LAST_NIB);

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next state
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (in_valid_i)  w_state_nxt = RUN;
            RUN:     if (w_last)      w_state_nxt = DONE;
            DONE:    if (out_ready_i) w_state_nxt = IDLE;
            default:                  w_state_nxt = IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // FSM: outputs
    // ------------------------------------------------------------------
    always_comb begin
        in_ready_o  = 1'b0;
        out_valid_o = 1'b0;
        case (r_state)
            IDLE:    in_ready_o  = 1'b1;
            DONE:    out_valid_o = 1'b1;
            default: ;
        endcase
    end

    // ------------------------------------------------------------------
    // Nibble datapath: operands are shifted right so the active nibble
    // is always bits [3:0].
    // ------------------------------------------------------------------
    assign w_p      = r_a[3:0] ^ r_b[3:0];
    assign w_g      = r_a[3:0] & r_b[3:0];
    assign w_g_fold = {w_g[3:1], w_g[0] | (w_p[0] & r_carry)};

    carry_tree_bk_4b u_carry_tree (
        .i_p  (w_p[3:1]),
        .i_g  (w_g_fold),
        .o_cx (w_cx)
    );

    assign w_sum = w_p ^ {w_cx[2:0], r_carry};

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_cnt       <= '0;
            r_a         <= '0;
            r_b         <= '0;
            r_carry     <= 1'b0;
            r_result    <= '0;
            r_carry_out <= 1'b0;
            r_ovf       <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (in_valid_i) begin
                        r_a     <= a_i;
                        // Subtract is A + ~B + 1; carry_i is ignored.
                        r_b     <= sub_i ? ~b_i : b_i;
                        r_carry <= sub_i | carry_i;
                        r_cnt   <= '0;
                    end
                end
                RUN: begin
                    r_a      <= r_a >> NIBBLE_W;
                    r_b      <= r_b >> NIBBLE_W;
                    // Nibbles enter at the top; after c_N shifts nibble 0
                    // has reached bits [3:0].
                    r_result <= {w_sum, r_result[WIDTH-1:NIBBLE_W]};
                    r_carry  <= w_cx[3];
                    if (w_last) begin
                        r_cnt       <= '0;
                        r_carry_out <= w_cx[3];
                        r_ovf       <= w_cx[3] ^ w_cx[2];
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign sum_o      = r_result;
    assign carry_o    = r_carry_out;
    assign overflow_o = r_ovf;

endmodule

`default_nettype wire

// File: tb/tb_adder_serial_bk.sv
// ============================================================================
//  Module   : tb_adder_serial_bk
//  Purpose  : Self-checking bench for adder_serial_bk (WIDTH=32): directed
//             vector table, back-pressure, mid-run reset and random ops
//             against an arithmetic reference model.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_adder_serial_bk;

    localparam int c_W = 32;
    localparam int c_N = c_W / 4;

    logic           clk_i = 1'b0;
    logic           rst_i;
    logic           in_valid_i;
    logic           in_ready_o;
    logic [c_W-1:0] a_i;
    logic [c_W-1:0] b_i;
    logic           carry_i;
    logic           sub_i;
    logic           out_valid_o;
    logic           out_ready_i;
    logic [c_W-1:0] sum_o;
    logic           carry_o;
    logic           overflow_o;

    int n_checks = 0;
    int n_fail   = 0;

    adder_serial_bk #(.WIDTH(c_W)) dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .in_valid_i  (in_valid_i),
        .in_ready_o  (in_ready_o),
        .a_i         (a_i),
        .b_i         (b_i),
        .carry_i     (carry_i),
        .sub_i       (sub_i),
        .out_valid_o (out_valid_o),
        .out_ready_i (out_ready_i),
        .sum_o       (sum_o),
        .carry_o     (carry_o),
        .overflow_o  (overflow_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic        cin;
        logic        sub;
        logic [31:0] exp_sum;
        logic        exp_c;
        logic        exp_ov;
    } vec_t;

    vec_t vecs[8];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference: plain unsigned/signed arithmetic on the full operands.
    function automatic void model(input logic [31:0] a, input logic [31:0] b,
                                  input logic cin, input logic sub,
                                  output logic [31:0] s, output logic c, output logic ov);
        longint      sa;
        longint      sb;
        longint      st;
        logic [32:0] u;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        if (sub) begin
            u  = {1'b0, a} - {1'b0, b};
            c  = (a >= b);
            st = sa - sb;
        end else begin
            u  = {1'b0, a} + {1'b0, b} + {32'd0, cin};
            c  = u[32];
            st = sa + sb + (cin ? 64'sd1 : 64'sd0);
        end
        s  = u[31:0];
        ov = (st > 64'sd2147483647) || (st < -64'sd2147483648);
    endfunction

    // Issue one operation and collect the result; lat counts edges from the
    // accepting edge (inclusive) to the first cycle with out_valid_o=1.
    task automatic run_op(input logic [31:0] a, input logic [31:0] b,
                          input logic cin, input logic sub,
                          output logic [31:0] s, output logic c, output logic ov,
                          output int lat);
        int w;
        w = 0;
        while (!in_ready_o && w < 50) begin
            @(negedge clk_i);
            w++;
        end
        if (!in_ready_o) check("in_ready timeout", 64'(in_ready_o), 64'd1);
        a_i        = a;
        b_i        = b;
        carry_i    = cin;
        sub_i      = sub;
        in_valid_i = 1'b1;
        @(posedge clk_i);
        lat = 1;
        @(negedge clk_i);
        // Scramble inputs: must not affect the running operation.
        in_valid_i = 1'b0;
        a_i        = $urandom;
        b_i        = $urandom;
        carry_i    = ~cin;
        sub_i      = ~sub;
        while (!out_valid_o && lat < 50) begin
            @(posedge clk_i);
            lat++;
            @(negedge clk_i);
        end
        if (!out_valid_o) check("out_valid timeout", 64'(out_valid_o), 64'd1);
        s  = sum_o;
        c  = carry_o;
        ov = overflow_o;
        out_ready_i = 1'b1;
        @(posedge clk_i);
        @(negedge clk_i);
        out_ready_i = 1'b0;
    endtask

    initial begin
        logic [31:0] s;
        logic [31:0] ms;
        logic [31:0] held_s;
        logic        c;
        logic        ov;
        logic        mc;
        logic        mov;
        logic        held_c;
        logic        held_ov;
        int          lat;
        int          w;
        logic [31:0] ra;
        logic [31:0] rb;
        logic        rcin;
        logic        rsub;

        vecs[0] = '{32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h0000_0000, 1'b1, 1'b0};
        vecs[1] = '{32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h8000_0000, 1'b0, 1'b1};
        vecs[2] = '{32'h0000_0005, 32'h0000_0007, 1'b0, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0};
        vecs[3] = '{32'h0000_0007, 32'h0000_0005, 1'b0, 1'b1, 32'h0000_0002, 1'b1, 1'b0};
        vecs[4] = '{32'h0000_000F, 32'h0000_0000, 1'b1, 1'b0, 32'h0000_0010, 1'b0, 1'b0};
        vecs[5] = '{32'h0000_000F, 32'h0000_0000, 1'b1, 1'b1, 32'h0000_000F, 1'b1, 1'b0};
        vecs[6] = '{32'h8000_0000, 32'h0000_0001, 1'b0, 1'b1, 32'h7FFF_FFFF, 1'b1, 1'b1};
        vecs[7] = '{32'h8000_0000, 32'h8000_0000, 1'b0, 1'b0, 32'h0000_0000, 1'b1, 1'b1};

        rst_i       = 1'b1;
        in_valid_i  = 1'b0;
        out_ready_i = 1'b0;
        a_i         = '0;
        b_i         = '0;
        carry_i     = 1'b0;
        sub_i       = 1'b0;
        repeat (2) @(posedge clk_i);
        @(negedge clk_i);
        rst_i = 1'b0;

        // Reset state
        check("reset in_ready",  64'(in_ready_o),  64'd1);
        check("reset out_valid", 64'(out_valid_o), 64'd0);
        check("reset sum",       64'(sum_o),       64'd0);
        check("reset carry",     64'(carry_o),     64'd0);
        check("reset overflow",  64'(overflow_o),  64'd0);

        // Directed vectors
        for (int i = 0; i < 8; i++) begin
            run_op(vecs[i].a, vecs[i].b, vecs[i].cin, vecs[i].sub, s, c, ov, lat);
            check($sformatf("vec%0d sum", i),      64'(s),  64'(vecs[i].exp_sum));
            check($sformatf("vec%0d carry", i),    64'(c),  64'(vecs[i].exp_c));
            check($sformatf("vec%0d overflow", i), 64'(ov), 64'(vecs[i].exp_ov));
            check($sformatf("vec%0d latency", i),  64'(lat), 64'(c_N + 1));
        end

        // Back-pressure: hold DONE with a competing in_valid_i
        @(negedge clk_i);
        a_i        = 32'h1234_5678;
        b_i        = 32'h1111_1111;
        carry_i    = 1'b0;
        sub_i      = 1'b0;
        in_valid_i = 1'b1;
        @(posedge clk_i);
        @(negedge clk_i);
        a_i = 32'hDEAD_BEEF;
        w = 0;
        while (!out_valid_o && w < 50) begin
            @(negedge clk_i);
            w++;
        end
        check("bp out_valid", 64'(out_valid_o), 64'd1);
        held_s  = sum_o;
        held_c  = carry_o;
        held_ov = overflow_o;
        check("bp sum value", 64'(held_s), 64'h2345_6789);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk_i);
            check("bp hold sum",       64'(sum_o),       64'(held_s));
            check("bp hold carry",     64'(carry_o),     64'(held_c));
            check("bp hold overflow",  64'(overflow_o),  64'(held_ov));
            check("bp in_ready low",   64'(in_ready_o),  64'd0);
            check("bp out_valid high", 64'(out_valid_o), 64'd1);
        end
        // Release with in_valid_i still high: no accept on the DONE->IDLE edge.
        out_ready_i = 1'b1;
        @(posedge clk_i);
        @(negedge clk_i);
        out_ready_i = 1'b0;
        in_valid_i  = 1'b0;
        check("bp release in_ready",  64'(in_ready_o),  64'd1);
        check("bp release out_valid", 64'(out_valid_o), 64'd0);

        // Reset on the 4th RUN cycle
        a_i        = 32'hA5A5_A5A5;
        b_i        = 32'h5A5A_5A5B;
        in_valid_i = 1'b1;
        @(posedge clk_i);
        @(negedge clk_i);
        in_valid_i = 1'b0;
        repeat (3) @(negedge clk_i);
        rst_i = 1'b1;
        @(posedge clk_i);
        @(negedge clk_i);
        rst_i = 1'b0;
        check("mid reset in_ready",  64'(in_ready_o),  64'd1);
        check("mid reset out_valid", 64'(out_valid_o), 64'd0);
        check("mid reset sum",       64'(sum_o),       64'd0);
        check("mid reset carry",     64'(carry_o),     64'd0);
        check("mid reset overflow",  64'(overflow_o),  64'd0);
        w = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk_i);
            if (out_valid_o) w++;
        end
        check("mid reset no out_valid pulse", 64'(w), 64'd0);

        // Post-reset operation works normally
        run_op(32'h0000_0003, 32'h0000_0004, 1'b0, 1'b0, s, c, ov, lat);
        check("post reset sum", 64'(s), 64'd7);

        // Random regression
        for (int i = 0; i < 2000; i++) begin
            ra   = $urandom;
            rb   = $urandom;
            rcin = 1'($urandom_range(0, 1));
            rsub = 1'($urandom_range(0, 1));
            case ($urandom_range(0, 7))
                0: ra = 32'hFFFF_FFFF;
                1: rb = 32'h8000_0000;
                2: rb = ra;
                default: ;
            endcase
            model(ra, rb, rcin, rsub, ms, mc, mov);
            run_op(ra, rb, rcin, rsub, s, c, ov, lat);
            check($sformatf("rand%0d sum", i),      64'(s),  64'(ms));
            check($sformatf("rand%0d carry", i),    64'(c),  64'(mc));
            check($sformatf("rand%0d overflow", i), 64'(ov), 64'(mov));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
